// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 convolution with line buffers, pipelined MAC tree and frame tracking.
// Define CONV_SAT_EN to clamp the output to the unsigned pixel range 0..2^PIX_W-1.
module conv3x3_stream #(
  parameter int PIX_W = 8,
  parameter int COEF_W = 4,
  parameter int IMG_W = 130,
  parameter int IMG_H = 130,
  localparam int RES_W = PIX_W + COEF_W + 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic [9*COEF_W-1:0]   coef,
  output logic                  out_valid,
  output logic [RES_W-1:0]      out_data,
  output logic                  out_last
);
  localparam int PW = PIX_W + COEF_W + 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [IMG_W-1:0][PIX_W-1:0] lb1, lb2;
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] win_in [3];
  logic signed [PW-1:0] prod [9];
  logic signed [RES_W-1:0] part [3];
  logic signed [RES_W-1:0] total;
  logic [RES_W-1:0] res;
  logic [3:0] v, l;
  logic col_end, row_end, fire;
  always_comb begin
    col_end = col == XW'(IMG_W - 1);
    row_end = row == YW'(IMG_H - 1);
    fire = in_valid && row >= YW'(2) && col >= XW'(2);
    win_in[0] = lb2[IMG_W-1];
    win_in[1] = lb1[IMG_W-1];
    win_in[2] = in_pixel;
  end
`ifdef CONV_SAT_EN
  localparam logic signed [RES_W-1:0] MAXP = RES_W'((1 << PIX_W) - 1);
  always_comb res = total[RES_W-1] ? '0 : (total > MAXP ? MAXP : total);
`else
  always_comb res = total;
`endif
  // Storage and datapath carry no reset: only validated windows ever reach the output.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb1 <= {lb1[IMG_W-2:0], in_pixel};
      lb2 <= {lb2[IMG_W-2:0], lb1[IMG_W-1]};
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= win_in[r];
      end
    end
    for (int k = 0; k < 9; k++)
      prod[k] <= PW'(signed'({1'b0, win[k/3][k%3]})) * PW'($signed(coef[k*COEF_W +: COEF_W]));
    for (int i = 0; i < 3; i++)
      part[i] <= RES_W'(prod[3*i]) + RES_W'(prod[3*i+1]) + RES_W'(prod[3*i+2]);
    total <= part[0] + part[1] + part[2];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      v <= '0;
      l <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      v <= {v[2:0], fire};
      l <= {l[2:0], fire && row_end && col_end};
      out_valid <= v[3];
      out_last <= l[3];
      if (v[3]) out_data <= res;
      if (in_valid) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= row_end ? '0 : row + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: table-driven check of conv3x3_stream on an 8x8 image against a reference convolution.
module tb_conv3x3_stream;
  localparam int PW = 8, CW = 4, W = 8, H = 8, RW = PW + CW + 5, SKIP = -99999;
`ifdef CONV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic [9*CW-1:0] coef = '0;
  logic out_valid, out_last;
  logic [RW-1:0] out_data;
  conv3x3_stream #(.PIX_W(PW), .COEF_W(CW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pixel(in_pixel), .coef(coef),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last));
  always #5 clk = ~clk;
  typedef struct {int val; bit last; int cyc;} exp_t;
  typedef struct {logic [35:0] coef; int mode; int gap; int exp_first; int exp_last; int frames;} vec_t;
  exp_t q[$];
  vec_t vecs[7];
  int checks = 0, errors = 0, cyc = 0, got = 0, first_val = 0, last_val = 0;
  int img [H][W];
  int rimg [H][W];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask
  function automatic logic [35:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {4'(a8), 4'(a7), 4'(a6), 4'(a5), 4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction
  function automatic int model(input logic [35:0] cf, input int y, input int x);
    int s = 0;
    logic signed [3:0] c4;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        c4 = cf[(3*r+c)*4 +: 4];
        s += int'(c4) * img[y-1+r][x-1+c];
      end
    if (SAT) s = s < 0 ? 0 : (s > 255 ? 255 : s);
    return s;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", int'($signed(out_data)), e.val);
        chk("last", int'(out_last), int'(e.last));
        chk("latency", cyc, e.cyc + 4);
        if (got == 0) first_val = int'($signed(out_data));
        last_val = int'($signed(out_data));
        got++;
      end
    end
  end
  task automatic run_frame(input int gap, input int npix);
    bit idle;
    for (int p = 0; p < npix; p++) begin
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        idle = $urandom_range(0, 99) < gap;
      end while (idle);
      in_valid = 1'b1;
      in_pixel = PW'(img[p/W][p%W]);
      if (p/W >= 2 && p%W >= 2)
        q.push_back('{model(coef, p/W - 1, p%W - 1), p == W*H - 1, cyc + 1});
    end
  endtask
  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    #3;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_last", int'(out_last), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rimg[y][x] = $urandom_range(0, 255);
    vecs[0] = '{mk9(0,-1,0,-1,4,-1,0,-1,0), 0, 0, 0, 0, 1};
    vecs[1] = '{mk9(0,0,0,0,1,0,0,0,0), 1, 0, 9, 54, 1};
    vecs[2] = '{mk9(-8,-8,-8,-8,-8,-8,-8,-8,-8), 2, 0, SAT ? 0 : -18360, SAT ? 0 : -18360, 1};
    vecs[3] = '{mk9(7,7,7,7,7,7,7,7,7), 2, 0, SAT ? 255 : 16065, SAT ? 255 : 16065, 1};
    vecs[4] = '{mk9(1,-2,3,-4,5,-6,7,-8,2), 3, 0, SKIP, SKIP, 1};
    vecs[5] = '{mk9(1,-2,3,-4,5,-6,7,-8,2), 3, 30, SKIP, SKIP, 1};
    vecs[6] = '{mk9(0,0,0,0,1,0,0,0,0), 1, 0, 9, 54, 3};
    for (int i = 0; i < 7; i++) begin
      coef = vecs[i].coef;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          img[y][x] = vecs[i].mode == 0 ? 1 : vecs[i].mode == 1 ? (8*y + x) % 256 :
                      vecs[i].mode == 2 ? 255 : rimg[y][x];
      got = 0;
      for (int f = 0; f < vecs[i].frames; f++) run_frame(vecs[i].gap, W*H);
      drain();
      chk($sformatf("count_v%0d", i), got, 36 * vecs[i].frames);
      if (vecs[i].exp_first != SKIP) begin
        chk($sformatf("first_v%0d", i), first_val, vecs[i].exp_first);
        chk($sformatf("lastval_v%0d", i), last_val, vecs[i].exp_last);
      end
    end
    coef = mk9(0,0,0,0,1,0,0,0,0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = rimg[y][x];
    run_frame(0, 3*W + 6);
    @(posedge clk);
    #3 reset = 1'b1;
    q.delete();
    #1;
    chk("midreset_valid", int'(out_valid), 0);
    chk("midreset_data", int'(out_data), 0);
    chk("midreset_last", int'(out_last), 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    got = 0;
    run_frame(0, W*H);
    drain();
    chk("count_after_reset", got, 36);
    chk("first_after_reset", first_val, rimg[1][1]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
